game_sequencer: RTL

Top-level play controller for the Pac-Man datapath. It decodes `collision_type` events into one-cycle pill, power-pill and ghost pulses, and drives the pill counter's increment and clear. It also owns lives, level, the frightened timer and the movement freeze. It sits between the collision detector and the pill counter, sprite movers and hex displays.

---
 rtl/game_pkg.sv | 29 ++
 rtl/event_decoder.sv | 44 ++++
 rtl/game_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the Pac-Man play controller, the collision detector
// and the pill counter.
//   game_state_t : sequencer FSM encoding, also driven out on the state port
//   collision_t  : collision codes produced by the detector
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    DYING = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } game_state_t;

  typedef enum logic [3:0] {
    NONE  = 4'b0000,
    PILL  = 4'b0010,
    POWER = 4'b0011,
    GHOST = 4'b0100
  } collision_t;

  localparam logic [3:0] LEVEL_MAX = 4'd15;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/event_decoder.sv
// Turns the level-held collision code and start button into one-cycle events.
// An event fires only on the first cycle a code appears; start fires on its
// rising edge.
// Ports:
//   clk_i, rst_i          : clock, async active-high reset
//   start_i               : synchronised start button
//   collision_type_i[3:0] : collision code from the detector
//   pill_evt_o, power_evt_o, ghost_evt_o, start_evt_o : one-cycle events
module event_decoder
  import game_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] collision_type_i,
  output logic       pill_evt_o,
  output logic       power_evt_o,
  output logic       ghost_evt_o,
  output logic       start_evt_o
);

  logic [3:0] col_q;
  logic       start_q;
  logic       col_new;

  // start_q resets high so a button held through reset is not seen as a
  // press until it has been released once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q   <= NONE;
      start_q <= 1'b1;
    end else begin
      col_q   <= collision_type_i;
      start_q <= start_i;
    end
  end

  assign col_new     = (collision_type_i != col_q);
  assign pill_evt_o  = col_new && (collision_type_i == PILL);
  assign power_evt_o = col_new && (collision_type_i == POWER);
  assign ghost_evt_o = col_new && (collision_type_i == GHOST);
  assign start_evt_o = start_i && !start_q;

endmodule

// File: rtl/game_sequencer.sv
// Top-level play controller: lives, level, pill counting, frightened timer and
// movement freeze. All outputs are registered.
// Ports:
//   CLOCK_50, reset      : clock, async active-high reset
//   start                : synchronised start button (rising edge acts)
//   collision_type[3:0]  : collision code from the detector
//   pill_inc, pill_clear : one-cycle pill counter controls
//   ghost_eaten          : one-cycle pulse, ghost eaten while frightened
//   freeze, frightened   : movement stop / ghosts vulnerable
//   lives[1:0], level[3:0], state[2:0] : status
//
// state | meaning
// IDLE  | power-up, waiting for start
// READY | frozen countdown before play
// PLAY  | normal play, events acted on
// DYING | death animation, lives already decremented
// CLEAR | level-clear pause, level already advanced
// OVER  | no lives left, waiting for start
module game_sequencer
  import game_pkg::*;
#(
  parameter int TOTAL_PILLS  = 150,
  parameter int READY_CYCLES = 100_000_000,
  parameter int POWER_CYCLES = 300_000_000,
  parameter int DEATH_CYCLES = 100_000_000,
  parameter int CLEAR_CYCLES = 100_000_000,
  parameter int START_LIVES  = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] collision_type,
  output logic       pill_inc,
  output logic       pill_clear,
  output logic       freeze,
  output logic       frightened,
  output logic       ghost_eaten,
  output logic [1:0] lives,
  output logic [3:0] level,
  output logic [2:0] state
);

  localparam int MAX_CYC  = max2(max2(READY_CYCLES, POWER_CYCLES),
                                 max2(DEATH_CYCLES, CLEAR_CYCLES));
  localparam int PHASE_W  = $clog2(MAX_CYC + 1);
  localparam int FRIGHT_W = $clog2(POWER_CYCLES + 1);

  // Phase timer is loaded with X-1 so the state is held for exactly X cycles.
  localparam logic [PHASE_W-1:0]  READY_LOAD = PHASE_W'(READY_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  DEATH_LOAD = PHASE_W'(DEATH_CYCLES - 1);
  localparam logic [PHASE_W-1:0]  CLEAR_LOAD = PHASE_W'(CLEAR_CYCLES - 1);
  localparam logic [FRIGHT_W-1:0] POWER_LOAD = FRIGHT_W'(POWER_CYCLES);
  localparam logic [7:0]          PILLS_LAST = 8'(TOTAL_PILLS);
  localparam logic [1:0]          LIVES_INIT = 2'(START_LIVES);

  logic pill_evt, power_evt, ghost_evt, start_evt;

  event_decoder u_event_decoder (
    .clk_i            (CLOCK_50),
    .rst_i            (reset),
    .start_i          (start),
    .collision_type_i (collision_type),
    .pill_evt_o       (pill_evt),
    .power_evt_o      (power_evt),
    .ghost_evt_o      (ghost_evt),
    .start_evt_o      (start_evt)
  );

  game_state_t         state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [FRIGHT_W-1:0] fright_q, fright_d;
  logic [7:0]          pills_q, pills_d;
  logic [1:0]          lives_q, lives_d;
  logic [3:0]          level_q, level_d;
  logic                pill_inc_q, pill_inc_d;
  logic                pill_clear_q, pill_clear_d;
  logic                ghost_q, ghost_d;
  logic                freeze_q, frightened_q;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      fright_q     <= '0;
      pills_q      <= '0;
      lives_q      <= '0;
      level_q      <= '0;
      pill_inc_q   <= 1'b0;
      pill_clear_q <= 1'b0;
      ghost_q      <= 1'b0;
      freeze_q     <= 1'b1;
      frightened_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      fright_q     <= fright_d;
      pills_q      <= pills_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      pill_inc_q   <= pill_inc_d;
      pill_clear_q <= pill_clear_d;
      ghost_q      <= ghost_d;
      freeze_q     <= (state_d != PLAY);
      frightened_q <= (fright_d != '0);
    end
  end

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    fright_d     = fright_q;
    pills_d      = pills_q;
    lives_d      = lives_q;
    level_d      = level_q;
    pill_inc_d   = 1'b0;
    pill_clear_d = 1'b0;
    ghost_d      = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start_evt) begin
          lives_d      = LIVES_INIT;
          level_d      = 4'd1;
          pills_d      = '0;
          pill_clear_d = 1'b1;
          phase_d      = READY_LOAD;
          state_d      = READY;
        end
      end

      READY: begin
        if (phase_q == '0) state_d = PLAY;
        else               phase_d = phase_q - PHASE_W'(1);
      end

      PLAY: begin
        if (fright_q != '0) fright_d = fright_q - FRIGHT_W'(1);
        if (pill_evt || power_evt) begin
          pill_inc_d = 1'b1;
          pills_d    = pills_q + 8'd1;
          if (power_evt) fright_d = POWER_LOAD;
          // Last pill wins over a power reload: frightened must drop on entry.
          if (pills_d == PILLS_LAST) begin
            state_d      = CLEAR;
            fright_d     = '0;
            pills_d      = '0;
            pill_clear_d = 1'b1;
            level_d      = (level_q == LEVEL_MAX) ? level_q : level_q + 4'd1;
            phase_d      = CLEAR_LOAD;
          end
        end else if (ghost_evt) begin
          if (fright_q != '0) begin
            ghost_d = 1'b1;
          end else begin
            state_d = DYING;
            lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
            phase_d = DEATH_LOAD;
          end
        end
      end

      DYING: begin
        fright_d = '0;
        if (phase_q == '0) begin
          if (lives_q == 2'd0) begin
            state_d = OVER;
          end else begin
            state_d = READY;
            phase_d = READY_LOAD;
          end
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end

      CLEAR: begin
        fright_d = '0;
        if (phase_q == '0) begin
          state_d = READY;
          phase_d = READY_LOAD;
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign pill_inc    = pill_inc_q;
  assign pill_clear  = pill_clear_q;
  assign ghost_eaten = ghost_q;
  assign freeze      = freeze_q;
  assign frightened  = frightened_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign state       = state_q;

endmodule
